// File: rtl/parking_sensor_conditioner_pkg.sv
// Shared constants and types for the parking-lot sensor front end.
//   DefaultCapacity        - default number of parking slots
//   DefaultDebounceCycles  - default debounce length in synchronised cycles
//   occ_width()            - smallest occupancy width able to hold 0..capacity
//   occ_event_e            - {entry_pulse, exit_pulse} decoded as an occupancy event
package parking_sensor_conditioner_pkg;

    localparam int unsigned DefaultCapacity       = 8;
    localparam int unsigned DefaultDebounceCycles = 4;

    function automatic int unsigned occ_width(input int unsigned capacity);
        return $clog2(capacity + 1);
    endfunction

    localparam int unsigned DefaultCntW = occ_width(DefaultCapacity);

    typedef enum logic [1:0] {
        EvNone  = 2'b00,
        EvExit  = 2'b01,
        EvEntry = 2'b10,
        EvBoth  = 2'b11
    } occ_event_e;

endpackage

// File: rtl/parking_sensor_conditioner_sensor_debounce.sv
// One sensor channel: 2-flop synchroniser, debounce counter and rising-edge pulse.
//   clk      in  clock, rising edge
//   rst_n    in  asynchronous active-low reset
//   raw_i    in  asynchronous sensor level
//   level_o  out debounced level
//   rise_o   out registered pulse, high in the first cycle level_o reads 1
module parking_sensor_conditioner_sensor_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o
);

    // Counter only ever holds 0..DEBOUNCE_CYCLES-1: it clears on the cycle it would reach the limit.
    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q, sync2_q;
    logic            stable_q, stable_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            rise_q, rise_d;

    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntLast) begin
            stable_d = ~stable_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
        rise_d = stable_d & ~stable_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            rise_q   <= 1'b0;
        end else begin
            sync1_q  <= raw_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            rise_q   <= rise_d;
        end
    end

    assign level_o = stable_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/parking_sensor_conditioner.sv
// Parking-lot sensor conditioner: debounced entry/exit levels for the gate controller,
// arrival/departure pulses and a saturating occupancy count with status/error flags.
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   entry/exit_sensor_raw_i  raw asynchronous loop sensors, 1 = vehicle present
//   entry/exit_detect_o      debounced levels
//   entry/exit_pulse_o       1-cycle pulse on debounced 0->1
//   occupancy_o              vehicles currently in the lot
//   lot_full_o / lot_empty_o occupancy == CAPACITY / occupancy == 0
//   entry_blocked_o          1-cycle pulse: arrival refused, lot full
//   underflow_err_o          sticky: departure seen with lot empty
module parking_sensor_conditioner
    import parking_sensor_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles,
    parameter int unsigned CAPACITY        = DefaultCapacity,
    parameter int unsigned CNT_W           = occ_width(CAPACITY)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             entry_sensor_raw_i,
    input  logic             exit_sensor_raw_i,
    output logic             entry_detect_o,
    output logic             exit_detect_o,
    output logic             entry_pulse_o,
    output logic             exit_pulse_o,
    output logic [CNT_W-1:0] occupancy_o,
    output logic             lot_full_o,
    output logic             lot_empty_o,
    output logic             entry_blocked_o,
    output logic             underflow_err_o
);

    localparam logic [CNT_W-1:0] OccFull = CNT_W'(CAPACITY);

    logic             entry_pulse, exit_pulse;
    occ_event_e       occ_event;
    logic [CNT_W-1:0] occ_q, occ_d;
    logic             blocked_q, blocked_d;
    logic             underflow_q, underflow_d;

    parking_sensor_conditioner_sensor_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_entry (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw_i  (entry_sensor_raw_i),
        .level_o(entry_detect_o),
        .rise_o (entry_pulse)
    );

    parking_sensor_conditioner_sensor_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_exit (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw_i  (exit_sensor_raw_i),
        .level_o(exit_detect_o),
        .rise_o (exit_pulse)
    );

    assign occ_event = occ_event_e'({entry_pulse, exit_pulse});

    always_comb begin
        occ_d       = occ_q;
        blocked_d   = 1'b0;
        underflow_d = underflow_q;
        unique case (occ_event)
            EvEntry: begin
                if (occ_q == OccFull) blocked_d = 1'b1;
                else                  occ_d     = occ_q + CNT_W'(1);
            end
            EvExit: begin
                if (occ_q == '0) underflow_d = 1'b1;
                else             occ_d       = occ_q - CNT_W'(1);
            end
            // Simultaneous arrival and departure cancel out at any occupancy.
            EvNone, EvBoth: ;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q       <= '0;
            blocked_q   <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            occ_q       <= occ_d;
            blocked_q   <= blocked_d;
            underflow_q <= underflow_d;
        end
    end

    assign entry_pulse_o   = entry_pulse;
    assign exit_pulse_o    = exit_pulse;
    assign occupancy_o     = occ_q;
    assign lot_full_o      = (occ_q == OccFull);
    assign lot_empty_o     = (occ_q == '0);
    assign entry_blocked_o = blocked_q;
    assign underflow_err_o = underflow_q;

endmodule

// File: tb/tb_parking_sensor_conditioner.sv
// Randomised and directed bench for parking_sensor_conditioner with an edge-level model.
module tb_parking_sensor_conditioner;

    localparam int DC  = 4;
    localparam int CAP = 3;
    localparam int CW  = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          entry_raw = 1'b0, exit_raw = 1'b0;
    logic          entry_detect, exit_detect, entry_pulse, exit_pulse;
    logic [CW-1:0] occupancy;
    logic          lot_full, lot_empty, entry_blocked, underflow_err;
    logic [9:0]    dut_v;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    parking_sensor_conditioner #(
        .DEBOUNCE_CYCLES(DC),
        .CAPACITY       (CAP),
        .CNT_W          (CW)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .entry_sensor_raw_i(entry_raw),
        .exit_sensor_raw_i (exit_raw),
        .entry_detect_o    (entry_detect),
        .exit_detect_o     (exit_detect),
        .entry_pulse_o     (entry_pulse),
        .exit_pulse_o      (exit_pulse),
        .occupancy_o       (occupancy),
        .lot_full_o        (lot_full),
        .lot_empty_o       (lot_empty),
        .entry_blocked_o   (entry_blocked),
        .underflow_err_o   (underflow_err)
    );

    assign dut_v = {entry_detect, exit_detect, entry_pulse, exit_pulse, occupancy,
                    lot_full, lot_empty, entry_blocked, underflow_err};

    // Model: raw samples per edge since reset; a level flips once the last DC synchronised
    // samples all disagree with it and DC edges have passed since the previous flip.
    bit samp0[$];
    bit samp1[$];
    bit mstable[2];
    bit mpulse[2];
    int last_flip[2];
    int mocc;
    bit mblocked, munder;
    int edge_n;

    function automatic bit sync_at(int ch, int e);
        if (e < 3) return 1'b0;
        return (ch == 0) ? samp0[e-3] : samp1[e-3];
    endfunction

    function automatic logic [9:0] exp_vec();
        return {mstable[0], mstable[1], mpulse[0], mpulse[1], CW'(mocc),
                mocc == CAP, mocc == 0, mblocked, munder};
    endfunction

    task automatic model_reset();
        samp0.delete();
        samp1.delete();
        for (int ch = 0; ch < 2; ch++) begin
            mstable[ch]   = 1'b0;
            mpulse[ch]    = 1'b0;
            last_flip[ch] = 0;
        end
        mocc = 0; mblocked = 1'b0; munder = 1'b0; edge_n = 0;
    endtask

    task automatic model_edge();
        bit old_p[2];
        bit all_diff;
        old_p = mpulse;
        edge_n++;
        samp0.push_back(entry_raw);
        samp1.push_back(exit_raw);
        for (int ch = 0; ch < 2; ch++) begin
            mpulse[ch] = 1'b0;
            if (edge_n - last_flip[ch] >= DC) begin
                all_diff = 1'b1;
                for (int e = edge_n - DC + 1; e <= edge_n; e++)
                    if (sync_at(ch, e) == mstable[ch]) all_diff = 1'b0;
                if (all_diff) begin
                    mstable[ch]   = ~mstable[ch];
                    last_flip[ch] = edge_n;
                    mpulse[ch]    = mstable[ch];
                end
            end
        end
        mblocked = 1'b0;
        if (old_p[0] && !old_p[1]) begin
            if (mocc == CAP) mblocked = 1'b1;
            else             mocc++;
        end else if (old_p[1] && !old_p[0]) begin
            if (mocc == 0) munder = 1'b1;
            else           mocc--;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
    endtask

    // One vehicle passing: raw high for 8 cycles then low for 8, model-checked each cycle.
    task automatic arrival(input bit en, input bit ex, input string tag, output int blocked_n);
        blocked_n = 0;
        for (int i = 0; i < 16; i++) begin
            entry_raw = en && (i < 8);
            exit_raw  = ex && (i < 8);
            tick();
            if (entry_blocked === 1'b1) blocked_n++;
            n_checks++;
            if (dut_v !== exp_vec())
                $display("FAIL %s cyc %0d: got %b expected %b", tag, edge_n, dut_v, exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        entry_raw = 0; exit_raw = 0;
        do_reset();
        n_checks++;
        if (dut_v !== 10'b0000_00_0100)
            $display("FAIL reset_state: got %b expected %b", dut_v, 10'b0000_00_0100);
        else n_pass++;
        for (int i = 0; i < 3; i++) tick();
        n_checks++;
        if (occupancy !== 2'd0 || lot_empty !== 1'b1)
            $display("FAIL reset_idle: got occ %0d empty %b expected 0/1", occupancy, lot_empty);
        else n_pass++;
    endtask

    task automatic test_entry_step();
        entry_raw = 1; exit_raw = 0;
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            tick();
            n_checks++;
            if (dut_v !== exp_vec())
                $display("FAIL entry_step cyc %0d: got %b expected %b", i, dut_v, exp_vec());
            else n_pass++;
            if (i == 5 || i == 6) begin
                n_checks++;
                if (entry_detect !== (i == 6) || entry_pulse !== (i == 6))
                    $display("FAIL entry_latency edge %0d: got det %b pulse %b expected %0d",
                             i, entry_detect, entry_pulse, i == 6);
                else n_pass++;
            end
            if (i == 7) begin
                n_checks++;
                if (entry_pulse !== 1'b0 || occupancy !== 2'd1)
                    $display("FAIL entry_count: got pulse %b occ %0d expected 0/1",
                             entry_pulse, occupancy);
                else n_pass++;
            end
        end
        entry_raw = 0;
        for (int i = 0; i < 10; i++) tick();
    endtask

    task automatic test_glitch();
        entry_raw = 0; exit_raw = 0;
        do_reset();
        for (int i = 0; i < 24; i++) begin
            entry_raw = ((i / 3) % 2) == 0;
            tick();
            n_checks++;
            if (dut_v !== exp_vec() || entry_detect !== 1'b0 || occupancy !== 2'd0)
                $display("FAIL glitch cyc %0d: got %b expected %b", i, dut_v, exp_vec());
            else n_pass++;
        end
        entry_raw = 0;
        for (int i = 0; i < 6; i++) tick();
    endtask

    task automatic test_fill_and_both();
        int bl, total_bl;
        int exp_occ[4] = '{1, 2, 3, 3};
        entry_raw = 0; exit_raw = 0;
        do_reset();
        total_bl = 0;
        for (int k = 0; k < 4; k++) begin
            arrival(1'b1, 1'b0, "fill", bl);
            total_bl += bl;
            n_checks++;
            if (occupancy !== CW'(exp_occ[k]) || lot_full !== (exp_occ[k] == CAP))
                $display("FAIL fill_occ arrival %0d: got occ %0d full %b expected %0d",
                         k + 1, occupancy, lot_full, exp_occ[k]);
            else n_pass++;
        end
        n_checks++;
        if (total_bl != 1)
            $display("FAIL fill_blocked: got %0d pulses expected 1", total_bl);
        else n_pass++;
        arrival(1'b1, 1'b1, "both", bl);
        n_checks++;
        if (bl != 0 || occupancy !== 2'd3)
            $display("FAIL both_hold: got blocked %0d occ %0d expected 0/3", bl, occupancy);
        else n_pass++;
    endtask

    task automatic test_underflow();
        int bl;
        entry_raw = 0; exit_raw = 0;
        do_reset();
        arrival(1'b0, 1'b1, "underflow", bl);
        n_checks++;
        if (underflow_err !== 1'b1 || occupancy !== 2'd0)
            $display("FAIL underflow_set: got err %b occ %0d expected 1/0",
                     underflow_err, occupancy);
        else n_pass++;
        for (int i = 0; i < 20; i++) tick();
        n_checks++;
        if (underflow_err !== 1'b1)
            $display("FAIL underflow_sticky: got %b expected 1", underflow_err);
        else n_pass++;
        do_reset();
        n_checks++;
        if (underflow_err !== 1'b0)
            $display("FAIL underflow_clear: got %b expected 0", underflow_err);
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        int bl, first_pulse, pulses;
        entry_raw = 0; exit_raw = 0;
        do_reset();
        arrival(1'b1, 1'b0, "mid_pre", bl);
        arrival(1'b1, 1'b0, "mid_pre", bl);
        entry_raw = 1;
        for (int i = 0; i < 3; i++) tick();
        rst_n = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (occupancy !== 2'd0 || entry_detect !== 1'b0)
            $display("FAIL async_reset: got occ %0d det %b expected 0/0", occupancy, entry_detect);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        first_pulse = -1; pulses = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (entry_pulse === 1'b1) begin
                pulses++;
                if (first_pulse < 0) first_pulse = i;
            end
            n_checks++;
            if (dut_v !== exp_vec())
                $display("FAIL mid_reset cyc %0d: got %b expected %b", i, dut_v, exp_vec());
            else n_pass++;
        end
        n_checks++;
        if (first_pulse != DC + 2 || pulses != 1 || occupancy !== 2'd1)
            $display("FAIL mid_reset_recount: got pulse@%0d x%0d occ %0d expected 6 x1 occ 1",
                     first_pulse, pulses, occupancy);
        else n_pass++;
        entry_raw = 0;
        for (int i = 0; i < 10; i++) tick();
    endtask

    task automatic test_random();
        entry_raw = 0; exit_raw = 0;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 9) == 0) entry_raw = ~entry_raw;
            if ($urandom_range(0, 11) == 0) exit_raw = ~exit_raw;
            tick();
            n_checks++;
            if (dut_v !== exp_vec())
                $display("FAIL random cyc %0d: got %b expected %b", i, dut_v, exp_vec());
            else n_pass++;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_entry_step();
        test_glitch();
        test_fill_and_both();
        test_underflow();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
